// File: rtl/sopc_timer_sched.sv
`default_nettype none
// ============================================================================
// Module   : sopc_timer_sched
// Purpose  : Round-robin one-shot timeout scheduler that shares one SOPC
//            interval timer among NREQ requesters via its register port.
// Option   : TIMER_SCHED_STATUS_CHECK_EN - read back status before clearing
// Revision : 1.0 - initial release
// ============================================================================
module sopc_timer_sched #(
    parameter int NREQ = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [32*NREQ-1:0]   period,
    input  logic [NREQ-1:0]      cancel,
    output logic [NREQ-1:0]      done,
    output logic                 busy,
    output logic [2:0]           grant_id,
    output logic [2:0]           tmr_address,
    output logic                 tmr_chipselect,
    output logic                 tmr_write_n,
    output logic [15:0]          tmr_writedata,
    input  logic [15:0]          tmr_readdata,
    input  logic                 tmr_irq
);

    localparam logic [2:0]  c_ADDR_STATUS  = 3'd0;
    localparam logic [2:0]  c_ADDR_CONTROL = 3'd1;
    localparam logic [2:0]  c_ADDR_PERL    = 3'd2;
    localparam logic [2:0]  c_ADDR_PERH    = 3'd3;
    localparam logic [15:0] c_CTL_START    = 16'h0005;
    localparam logic [15:0] c_CTL_STOP     = 16'h0008;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_WR_PL  = 4'd1,
        ST_WR_PH  = 4'd2,
        ST_WR_CTL = 4'd3,
        ST_WAIT   = 4'd4,
        ST_STOP   = 4'd5,
        ST_CLR_ST = 4'd6,
        ST_DONE   = 4'd7
`ifdef TIMER_SCHED_STATUS_CHECK_EN
        , ST_RD_ST = 4'd8
`endif
    } state_t;

    state_t          r_state;
    logic [NREQ-1:0] r_pending;
    logic [31:0]     r_period [NREQ];
    logic [31:0]     r_act_period;
    logic [2:0]      r_grant;
    logic [2:0]      r_last_grant;
    logic            r_abort_q;
    logic            r_aborted;
`ifdef TIMER_SCHED_STATUS_CHECK_EN
    logic            r_rd_cnt;
    logic            w_unused_rd;
    assign w_unused_rd = ^tmr_readdata[15:1];
`else
    logic            w_unused_rd;
    assign w_unused_rd = ^tmr_readdata;
`endif

    logic [31:0]     w_per_in [NREQ];
    logic            w_found;
    logic [2:0]      w_next;
    logic [31:0]     w_sel_period;
    logic [NREQ-1:0] w_sel_oh;
    logic [NREQ-1:0] w_grant_oh;
    logic            w_cancel_act;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_per
        assign w_per_in[gi] = period[32*gi +: 32];
    end

    // Scan downward so the candidate closest after last_grant is kept last.
    always_comb begin
        w_found = 1'b0;
        w_next  = '0;
        for (int k = NREQ; k >= 1; k--) begin
            if (r_pending[(int'(r_last_grant) + k) % NREQ]) begin
                w_found = 1'b1;
                w_next  = 3'((int'(r_last_grant) + k) % NREQ);
            end
        end
    end

    always_comb begin
        w_sel_oh     = '0;
        w_grant_oh   = '0;
        w_sel_period = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_sel_oh[i]   = (r_state == ST_IDLE) && w_found && (w_next == 3'(i));
            w_grant_oh[i] = (r_grant == 3'(i));
            if (w_next == 3'(i))
                w_sel_period = w_sel_period | r_period[i];
        end
        w_cancel_act = |(cancel & w_grant_oh);
    end

    // Cancel beats both a same-cycle request and the grant that clears it.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NREQ; i++) begin
            if (reset || cancel[i] || w_sel_oh[i])
                r_pending[i] <= 1'b0;
            else if (req[i])
                r_pending[i] <= 1'b1;
            if (req[i] && !r_pending[i] && !cancel[i])
                r_period[i] <= (w_per_in[i] == 32'd0) ? 32'd1 : w_per_in[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_abort_q    <= 1'b0;
            r_aborted    <= 1'b0;
            r_grant      <= 3'd0;
            r_last_grant <= 3'(NREQ - 1);
            r_act_period <= '0;
`ifdef TIMER_SCHED_STATUS_CHECK_EN
            r_rd_cnt     <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_grant      <= w_next;
                        r_last_grant <= w_next;
                        r_act_period <= w_sel_period;
                        r_abort_q    <= 1'b0;
                        r_aborted    <= 1'b0;
                        r_state      <= ST_WR_PL;
                    end
                end
                ST_WR_PL: begin
                    if (w_cancel_act) r_abort_q <= 1'b1;
                    r_state <= ST_WR_PH;
                end
                ST_WR_PH: begin
                    if (w_cancel_act) r_abort_q <= 1'b1;
                    r_state <= ST_WR_CTL;
                end
                ST_WR_CTL: begin
                    if (w_cancel_act) r_abort_q <= 1'b1;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (tmr_irq) begin
                        r_abort_q <= 1'b0;
`ifdef TIMER_SCHED_STATUS_CHECK_EN
                        r_rd_cnt  <= 1'b0;
                        r_state   <= ST_RD_ST;
`else
                        r_state   <= ST_CLR_ST;
`endif
                    end else if (r_abort_q || w_cancel_act) begin
                        r_abort_q <= 1'b0;
                        r_state   <= ST_STOP;
                    end
                end
`ifdef TIMER_SCHED_STATUS_CHECK_EN
                // Read data is valid on the second cycle of the status read.
                ST_RD_ST: begin
                    if (w_cancel_act) r_abort_q <= 1'b1;
                    if (!r_rd_cnt) begin
                        r_rd_cnt <= 1'b1;
                    end else begin
                        r_rd_cnt <= 1'b0;
                        if (tmr_readdata[0]) begin
                            r_abort_q <= 1'b0;
                            r_state   <= ST_CLR_ST;
                        end else begin
                            r_state   <= ST_WAIT;
                        end
                    end
                end
`endif
                ST_STOP: begin
                    r_aborted <= 1'b1;
                    r_state   <= ST_CLR_ST;
                end
                ST_CLR_ST: r_state <= r_aborted ? ST_IDLE : ST_DONE;
                ST_DONE:   r_state <= ST_IDLE;
                default:   r_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        tmr_address    = '0;
        tmr_chipselect = 1'b0;
        tmr_write_n    = 1'b1;
        tmr_writedata  = '0;
        case (r_state)
            ST_WR_PL: begin
                tmr_address    = c_ADDR_PERL;
                tmr_chipselect = 1'b1;
                tmr_write_n    = 1'b0;
                tmr_writedata  = r_act_period[15:0];
            end
            ST_WR_PH: begin
                tmr_address    = c_ADDR_PERH;
                tmr_chipselect = 1'b1;
                tmr_write_n    = 1'b0;
                tmr_writedata  = r_act_period[31:16];
            end
            ST_WR_CTL: begin
                tmr_address    = c_ADDR_CONTROL;
                tmr_chipselect = 1'b1;
                tmr_write_n    = 1'b0;
                tmr_writedata  = c_CTL_START;
            end
            ST_STOP: begin
                tmr_address    = c_ADDR_CONTROL;
                tmr_chipselect = 1'b1;
                tmr_write_n    = 1'b0;
                tmr_writedata  = c_CTL_STOP;
            end
            ST_CLR_ST: begin
                tmr_address    = c_ADDR_STATUS;
                tmr_chipselect = 1'b1;
                tmr_write_n    = 1'b0;
            end
`ifdef TIMER_SCHED_STATUS_CHECK_EN
            ST_RD_ST: begin
                tmr_address    = c_ADDR_STATUS;
                tmr_chipselect = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign done     = (r_state == ST_DONE) ? w_grant_oh : '0;
    assign busy     = (r_state != ST_IDLE);
    assign grant_id = r_grant;

endmodule
`default_nettype wire

// File: tb/tb_sopc_timer_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_sopc_timer_sched
// Purpose  : Self-checking bench for sopc_timer_sched with a request model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sopc_timer_sched;
    localparam int NREQ = 4;
`ifdef TIMER_SCHED_STATUS_CHECK_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NREQ-1:0]      req;
    logic [NREQ-1:0]      cancel;
    logic [32*NREQ-1:0]   period;
    logic [NREQ-1:0]      done;
    logic                 busy;
    logic [2:0]           grant_id;
    logic [2:0]           tmr_address;
    logic                 tmr_chipselect;
    logic                 tmr_write_n;
    logic [15:0]          tmr_writedata;
    logic [15:0]          tmr_readdata;
    logic                 tmr_irq;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    sopc_timer_sched #(.NREQ(NREQ)) dut (
        .clk(clk), .reset(reset), .req(req), .period(period), .cancel(cancel),
        .done(done), .busy(busy), .grant_id(grant_id),
        .tmr_address(tmr_address), .tmr_chipselect(tmr_chipselect),
        .tmr_write_n(tmr_write_n), .tmr_writedata(tmr_writedata),
        .tmr_readdata(tmr_readdata), .tmr_irq(tmr_irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int cyc; logic [2:0] addr; logic [15:0] data; } wr_t;
    wr_t wq[$];
    int  dn_id[$];
    int  dn_cyc[$];

    // Bus and done monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (tmr_chipselect === 1'b1 && tmr_write_n === 1'b0)
            wq.push_back('{cyc: cyc, addr: tmr_address, data: tmr_writedata});
        for (int i = 0; i < NREQ; i++)
            if (done[i] === 1'b1) begin
                dn_id.push_back(i);
                dn_cyc.push_back(cyc);
            end
    end

    // Reference model: pending set, latched periods, round-robin pointer.
    bit          m_pend [NREQ];
    logic [31:0] m_per  [NREQ];
    int          m_last;

    function automatic void model_reset();
        for (int i = 0; i < NREQ; i++) m_pend[i] = 1'b0;
        m_last = NREQ - 1;
    endfunction

    function automatic void model_strobe(input logic [NREQ-1:0] r, input logic [NREQ-1:0] c,
                                         input logic [32*NREQ-1:0] p);
        for (int i = 0; i < NREQ; i++) begin
            if (c[i]) m_pend[i] = 1'b0;
            else if (r[i] && !m_pend[i]) begin
                m_pend[i] = 1'b1;
                m_per[i]  = (p[32*i +: 32] == 32'd0) ? 32'd1 : p[32*i +: 32];
            end
        end
    endfunction

    function automatic int model_grant();
        for (int k = 1; k <= NREQ; k++) begin
            int j = (m_last + k) % NREQ;
            if (m_pend[j]) begin
                m_pend[j] = 1'b0;
                m_last    = j;
                return j;
            end
        end
        return -1;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        wq.delete(); dn_id.delete(); dn_cyc.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1; req = '0; cancel = '0; tmr_irq = 1'b0;
        tick(2);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic strobe(input logic [NREQ-1:0] r, input logic [NREQ-1:0] c);
        req = r; cancel = c;
        tick(1);
        req = '0; cancel = '0;
    endtask

    task automatic set_period(input int i, input logic [31:0] p);
        period[32*i +: 32] = p;
    endtask

    task automatic wait_prog(output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 20 && !ok; t++) begin
            tick(1);
            ok = (wq.size() >= 3);
        end
    endtask

    // Ends a service in WAIT; kcyc is the cycle count of the sampling edge.
    task automatic finish(input bit irq_on, input bit cancel_on, input int g, output int kcyc);
        tmr_irq = irq_on;
        if (cancel_on) cancel[g] = 1'b1;
        tick(1);
        tmr_irq = 1'b0; cancel = '0;
        kcyc = cyc;
        tick(irq_on ? 2 + LAT : 2);
    endtask

    task automatic test_reset();
        reset = 1'b1; req = '0; cancel = '0; tmr_irq = 1'b0; period = '0;
        tmr_readdata = 16'h0001;
        tick(3);
        n_chk++;
        if (busy !== 1'b0 || done !== '0 || grant_id !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: busy=%b done=%b grant=%0d, want 0/0/0", busy, done, grant_id);
        end
        n_chk++;
        if (tmr_chipselect !== 1'b0 || tmr_write_n !== 1'b1 || tmr_address !== 3'd0 || tmr_writedata !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_bus: cs=%b wn=%b a=%0d d=%h, want 0/1/0/0000",
                     tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata);
        end
        reset = 1'b0;
        model_reset();
        clear_mon();
        tick(3);
        n_chk++;
        if (busy !== 1'b0 || wq.size() != 0) begin
            n_fail++;
            $display("FAIL reset_nopending: busy=%b writes=%0d, want 0/0", busy, wq.size());
        end
    endtask

    task automatic test_single();
        bit ok; int k;
        clear_mon();
        set_period(1, 32'h0001_0010);
        strobe(4'b0010, 4'b0000);
        wait_prog(ok);
        n_chk++;
        if (!ok || wq[0].addr !== 3'd2 || wq[0].data !== 16'h0010 || wq[1].addr !== 3'd3 ||
            wq[1].data !== 16'h0001 || wq[2].addr !== 3'd1 || wq[2].data !== 16'h0005) begin
            n_fail++;
            $display("FAIL single_prog: got a%0d=%h a%0d=%h a%0d=%h, want a2=0010 a3=0001 a1=0005",
                     wq[0].addr, wq[0].data, wq[1].addr, wq[1].data, wq[2].addr, wq[2].data);
        end
        n_chk++;
        if (!ok || wq[1].cyc != wq[0].cyc + 1 || wq[2].cyc != wq[0].cyc + 2 || grant_id !== 3'd1) begin
            n_fail++;
            $display("FAIL single_seq: grant=%0d consecutive=%b, want 1/1", grant_id,
                     wq[1].cyc == wq[0].cyc + 1 && wq[2].cyc == wq[0].cyc + 2);
        end
        finish(1'b1, 1'b0, 1, k);
        n_chk++;
        if (wq.size() != 4 || wq[3].addr !== 3'd0 || wq[3].data !== 16'h0 || wq[3].cyc != k + LAT) begin
            n_fail++;
            $display("FAIL single_clear: writes=%0d last a%0d=%h, want 4 writes ending a0=0000", wq.size(), wq[3].addr, wq[3].data);
        end
        n_chk++;
        if (dn_id.size() != 1 || dn_id[0] != 1 || dn_cyc[0] != k + 1 + LAT || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_done: pulses=%0d id=%0d lat=%0d busy=%b, want 1/1/%0d/0",
                     dn_id.size(), dn_id[0], dn_cyc[0] - k, busy, 1 + LAT);
        end
    endtask

    task automatic test_round_robin();
        bit ok; int k; logic [31:0] p [NREQ];
        int order [6] = '{0, 1, 2, 3, 0, 3};
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            p[i] = $urandom() | 32'h1;
            set_period(i, p[i]);
        end
        strobe(4'b1111, 4'b0000);
        for (int n = 0; n < 6; n++) begin
            if (n == 4) strobe(4'b1001, 4'b0000);
            clear_mon();
            wait_prog(ok);
            n_chk++;
            if (!ok || grant_id !== 3'(order[n]) || wq[0].data !== p[order[n]][15:0] ||
                wq[1].data !== p[order[n]][31:16]) begin
                n_fail++;
                $display("FAIL rr_grant%0d: grant=%0d pl=%h ph=%h, want %0d %h %h", n, grant_id,
                         wq[0].data, wq[1].data, order[n], p[order[n]][15:0], p[order[n]][31:16]);
            end
            finish(1'b1, 1'b0, order[n], k);
            n_chk++;
            if (dn_id.size() != 1 || dn_id[0] != order[n]) begin
                n_fail++;
                $display("FAIL rr_done%0d: pulses=%0d id=%0d, want 1/%0d", n, dn_id.size(), dn_id[0], order[n]);
            end
        end
    endtask

    task automatic test_cancel();
        bit ok; int k;
        clear_mon();
        set_period(2, 32'h0000_0100);
        strobe(4'b0100, 4'b0000);
        wait_prog(ok);
        finish(1'b0, 1'b1, 2, k);
        n_chk++;
        if (!ok || wq.size() != 5 || wq[3].addr !== 3'd1 || wq[3].data !== 16'h0008 || wq[3].cyc != k ||
            wq[4].addr !== 3'd0 || wq[4].data !== 16'h0 || wq[4].cyc != k + 1) begin
            n_fail++;
            $display("FAIL cancel_wait_bus: writes=%0d a%0d=%h a%0d=%h, want 5 with a1=0008 a0=0000",
                     wq.size(), wq[3].addr, wq[3].data, wq[4].addr, wq[4].data);
        end
        n_chk++;
        if (dn_id.size() != 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL cancel_wait_done: pulses=%0d busy=%b, want 0/0", dn_id.size(), busy);
        end
        clear_mon();
        strobe(4'b0001, 4'b0000);
        tick(1);
        cancel[0] = 1'b1;
        tick(1);
        cancel = '0;
        tick(6);
        n_chk++;
        if (wq.size() != 5 || wq[3].data !== 16'h0008 || wq[3].cyc != wq[2].cyc + 2 ||
            wq[4].addr !== 3'd0 || dn_id.size() != 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL cancel_prog: writes=%0d stop=%h gap=%0d pulses=%0d busy=%b, want 5/0008/2/0/0",
                     wq.size(), wq[3].data, wq[3].cyc - wq[2].cyc, dn_id.size(), busy);
        end
    endtask

    task automatic test_simultaneous();
        bit ok; int k;
        clear_mon();
        set_period(1, 32'h0000_0040);
        strobe(4'b0010, 4'b0000);
        wait_prog(ok);
        finish(1'b1, 1'b1, 1, k);
        n_chk++;
        if (!ok || wq.size() != 4 || wq[3].addr !== 3'd0 || dn_id.size() != 1 || dn_id[0] != 1) begin
            n_fail++;
            $display("FAIL irq_cancel: writes=%0d last_a=%0d pulses=%0d, want 4/0/1", wq.size(), wq[3].addr, dn_id.size());
        end
        clear_mon();
        strobe(4'b1000, 4'b1000);
        tick(3);
        n_chk++;
        if (busy !== 1'b0 || wq.size() != 0) begin
            n_fail++;
            $display("FAIL req_cancel_same: busy=%b writes=%0d, want 0/0", busy, wq.size());
        end
    endtask

    task automatic test_period_zero();
        bit ok; int k;
        clear_mon();
        set_period(0, 32'h0);
        strobe(4'b0001, 4'b0000);
        wait_prog(ok);
        n_chk++;
        if (!ok || wq[0].data !== 16'h0001 || wq[1].data !== 16'h0000) begin
            n_fail++;
            $display("FAIL period_zero: pl=%h ph=%h, want 0001 0000", wq[0].data, wq[1].data);
        end
        finish(1'b1, 1'b0, 0, k);
    endtask

    task automatic test_back_to_back();
        bit ok; int k;
        clear_mon();
        set_period(2, 32'h0003_0030);
        strobe(4'b0100, 4'b0000);
        wait_prog(ok);
        set_period(2, 32'h0007_0070);
        strobe(4'b0100, 4'b0000);
        finish(1'b1, 1'b0, 2, k);
        n_chk++;
        if (!ok || wq[0].data !== 16'h0030 || dn_id.size() != 1 || dn_id[0] != 2) begin
            n_fail++;
            $display("FAIL b2b_first: pl=%h pulses=%0d, want 0030/1", wq[0].data, dn_id.size());
        end
        clear_mon();
        wait_prog(ok);
        n_chk++;
        if (!ok || grant_id !== 3'd2 || wq[0].data !== 16'h0070 || wq[1].data !== 16'h0007 ||
            wq[0].cyc != k + 3 + LAT) begin
            n_fail++;
            $display("FAIL b2b_second: grant=%0d pl=%h ph=%h gap=%0d, want 2 0070 0007 %0d",
                     grant_id, wq[0].data, wq[1].data, wq[0].cyc - k, 3 + LAT);
        end
        finish(1'b1, 1'b0, 2, k);
    endtask

    task automatic test_reset_in_wait();
        bit ok;
        clear_mon();
        set_period(1, 32'h0000_0200);
        strobe(4'b0010, 4'b0000);
        wait_prog(ok);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        model_reset();
        n_chk++;
        if (!ok || busy !== 1'b0 || tmr_chipselect !== 1'b0 || tmr_write_n !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_wait: busy=%b cs=%b wn=%b, want 0/0/1", busy, tmr_chipselect, tmr_write_n);
        end
        tmr_irq = 1'b1;
        tick(1);
        tmr_irq = 1'b0;
        tick(4);
        n_chk++;
        if (dn_id.size() != 0 || busy !== 1'b0 || wq.size() != 3) begin
            n_fail++;
            $display("FAIL reset_wait_irq: pulses=%0d busy=%b writes=%0d, want 0/0/3", dn_id.size(), busy, wq.size());
        end
    endtask

`ifdef TIMER_SCHED_STATUS_CHECK_EN
    task automatic test_spurious();
        bit ok; int k;
        clear_mon();
        set_period(1, 32'h0000_0050);
        strobe(4'b0010, 4'b0000);
        wait_prog(ok);
        tmr_readdata = 16'h0000;
        tmr_irq = 1'b1;
        tick(1);
        tmr_irq = 1'b0;
        tick(4);
        n_chk++;
        if (!ok || wq.size() != 3 || busy !== 1'b1 || dn_id.size() != 0) begin
            n_fail++;
            $display("FAIL spurious: writes=%0d busy=%b pulses=%0d, want 3/1/0", wq.size(), busy, dn_id.size());
        end
        tmr_readdata = 16'h0001;
        finish(1'b1, 1'b0, 1, k);
        n_chk++;
        if (wq.size() != 4 || wq[3].addr !== 3'd0 || dn_id.size() != 1 || dn_id[0] != 1) begin
            n_fail++;
            $display("FAIL spurious_then_real: writes=%0d pulses=%0d, want 4/1", wq.size(), dn_id.size());
        end
    endtask
`endif

    task automatic test_random();
        logic [NREQ-1:0] r, c;
        logic [31:0] ep;
        int g, o, a, k;
        bit ok;
        do_reset();
        for (int it = 0; it < 25; it++) begin
            r = NREQ'($urandom_range(1, 2**NREQ - 1));
            c = ($urandom_range(0, 3) == 0) ? NREQ'($urandom()) : '0;
            for (int i = 0; i < NREQ; i++)
                set_period(i, ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom());
            model_strobe(r, c, period);
            strobe(r, c);
            g = model_grant();
            while (g >= 0) begin
                ep = m_per[g];
                clear_mon();
                wait_prog(ok);
                n_chk++;
                if (!ok || grant_id !== 3'(g) || wq[0].data !== ep[15:0] || wq[1].data !== ep[31:16] ||
                    wq[2].data !== 16'h0005) begin
                    n_fail++;
                    $display("FAIL rand_prog it%0d: grant=%0d pl=%h ph=%h, want %0d %h %h",
                             it, grant_id, wq[0].data, wq[1].data, g, ep[15:0], ep[31:16]);
                end
                a = $urandom_range(0, 3);
                if (a == 3) begin
                    o = (g + $urandom_range(1, NREQ - 1)) % NREQ;
                    cancel[o] = 1'b1;
                    tick(1);
                    cancel = '0;
                    m_pend[o] = 1'b0;
                end
                finish(a != 0, a <= 1, g, k);
                n_chk++;
                if (a == 0) begin
                    if (wq.size() != 5 || wq[3].data !== 16'h0008 || wq[4].addr !== 3'd0 || dn_id.size() != 0) begin
                        n_fail++;
                        $display("FAIL rand_cancel it%0d: writes=%0d pulses=%0d, want 5/0", it, wq.size(), dn_id.size());
                    end
                end else begin
                    if (wq.size() != 4 || wq[3].addr !== 3'd0 || dn_id.size() != 1 || dn_id[0] != g ||
                        dn_cyc[0] != k + 1 + LAT) begin
                        n_fail++;
                        $display("FAIL rand_done it%0d: writes=%0d pulses=%0d id=%0d, want 4/1/%0d",
                                 it, wq.size(), dn_id.size(), dn_id[0], g);
                    end
                end
                g = model_grant();
            end
            n_chk++;
            if (busy !== 1'b0) begin
                n_fail++;
                $display("FAIL rand_idle it%0d: busy=%b, want 0", it, busy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_cancel();
        test_simultaneous();
        test_period_zero();
        test_back_to_back();
        test_reset_in_wait();
`ifdef TIMER_SCHED_STATUS_CHECK_EN
        test_spurious();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule
`default_nettype wire
